// File: rtl/hc_pkg.sv
// Shared constants and types for the c0 read reorder buffer.
// Tags index the entry store; pointers carry one extra wrap bit.
package hc_pkg;

  localparam int HC_ROB_DEPTH = 16;
  localparam int HC_ROB_DW    = 512;
  localparam int HC_ROB_BIDW  = 4;
  localparam int HC_ROB_TAG_W = $clog2(HC_ROB_DEPTH);

  typedef logic [HC_ROB_TAG_W-1:0] t_rob_tag;
  typedef logic [HC_ROB_TAG_W:0]   t_rob_ptr;

  typedef struct packed {
    logic pending;
    logic filled;
  } t_rob_flags;

  typedef struct packed {
    logic                   pending;
    logic                   filled;
    logic [HC_ROB_BIDW-1:0] bid;
  } t_rob_entry;

endpackage

// File: rtl/hc_rob_mem.sv
// Response line store: synchronous write by tag,
// asynchronous read at the head index.
module hc_rob_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hc_read_reorder.sv
// Issues in-order tags for c0 reads and returns the
// out-of-order responses to the core in issue order.
module hc_read_reorder
  import hc_pkg::*;
#(
  parameter int HC_ROB_DEPTH = 16,
  parameter int HC_ROB_DW    = 512,
  parameter int HC_ROB_BIDW  = 4,
  parameter int TAG_W        = $clog2(HC_ROB_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alloc_req,
  input  logic [HC_ROB_BIDW-1:0] alloc_bid,
  output logic                   alloc_gnt,
  output logic [TAG_W-1:0]       alloc_tag,
  input  logic                   rsp_valid,
  input  logic [TAG_W-1:0]       rsp_tag,
  input  logic [HC_ROB_DW-1:0]   rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [HC_ROB_DW-1:0]   out_data,
  output logic [HC_ROB_BIDW-1:0] out_bid,
  output logic [TAG_W:0]         count,
  output logic                   err_unexp
);

  logic [TAG_W:0]   head, tail;
  logic [TAG_W:0]   head_nx, tail_nx;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             full;
  logic             alloc_fire;
  logic             pop;
  logic             rsp_ok;

  t_rob_flags [HC_ROB_DEPTH-1:0] flg;
  logic [HC_ROB_BIDW-1:0]        bid_q [HC_ROB_DEPTH];

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign full     = (head[TAG_W] != tail[TAG_W])
                 && (head_idx == tail_idx);

  // Grant and tag depend on pointer state only.
  assign alloc_gnt = !full;
  assign alloc_tag = tail_idx;

  assign out_valid = flg[head_idx].filled;
  assign out_bid   = bid_q[head_idx];

  assign alloc_fire = alloc_req && alloc_gnt;
  assign pop        = out_valid && out_ready;

  // Judged on pre-alloc state, so a reply to the
  // tag being issued right now counts as unexpected.
  assign rsp_ok = rsp_valid
               && flg[rsp_tag].pending
               && !flg[rsp_tag].filled;

  assign head_nx = head + {{TAG_W{1'b0}}, pop};
  assign tail_nx = tail + {{TAG_W{1'b0}}, alloc_fire};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      flg       <= '0;
      err_unexp <= 1'b0;
    end else begin
      head  <= head_nx;
      tail  <= tail_nx;
      count <= tail_nx - head_nx;
      if (pop) begin
        flg[head_idx].pending <= 1'b0;
        flg[head_idx].filled  <= 1'b0;
      end
      if (alloc_fire) begin
        flg[tail_idx].pending <= 1'b1;
        flg[tail_idx].filled  <= 1'b0;
      end
      if (rsp_ok) flg[rsp_tag].filled <= 1'b1;
      if (rsp_valid && !rsp_ok) err_unexp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) bid_q[tail_idx] <= alloc_bid;
  end

  hc_rob_mem #(
    .DEPTH (HC_ROB_DEPTH),
    .DW    (HC_ROB_DW),
    .AW    (TAG_W)
  ) u_mem (
    .clk   (clk),
    .we    (rsp_ok),
    .waddr (rsp_tag),
    .wdata (rsp_data),
    .raddr (head_idx),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_hc_read_reorder.sv
// Randomised bench for hc_read_reorder against a
// queue model of outstanding reads in issue order.
module tb_hc_read_reorder;
  import hc_pkg::*;

  localparam int D  = HC_ROB_DEPTH;
  localparam int DW = HC_ROB_DW;
  localparam int BW = HC_ROB_BIDW;
  localparam int TW = $clog2(D);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alloc_req;
  logic [BW-1:0] alloc_bid;
  logic          alloc_gnt;
  logic [TW-1:0] alloc_tag;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tag;
  logic [DW-1:0] rsp_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [BW-1:0] out_bid;
  logic [TW:0]   count;
  logic          err_unexp;

  always #5 clk = ~clk;

  hc_read_reorder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alloc_req (alloc_req),
    .alloc_bid (alloc_bid),
    .alloc_gnt (alloc_gnt),
    .alloc_tag (alloc_tag),
    .rsp_valid (rsp_valid),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bid   (out_bid),
    .count     (count),
    .err_unexp (err_unexp)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [BW-1:0] bid;
    bit            filled;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic [TW-1:0] nxt;
  bit            m_err;
  int            n_tests;
  int            n_fail;

  task automatic chk(input string t,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", t, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_all();
    bit v;
    v = (q.size() > 0) && q[0].filled;
    chk("alloc_gnt", alloc_gnt, q.size() < D);
    chk("alloc_tag", alloc_tag, nxt);
    chk("count", count, q.size());
    chk("err_unexp", err_unexp, m_err);
    chk("out_valid", out_valid, v);
    if (v) begin
      chk("out_data", out_data, q[0].data);
      chk("out_bid", out_bid, q[0].bid);
    end
  endtask

  task automatic cyc(input bit a_req, input logic [BW-1:0] a_bid,
                     input bit r_v, input logic [TW-1:0] r_tag,
                     input logic [DW-1:0] r_data, input bit o_rdy);
    bit fire, pop;
    int k;
    alloc_req = a_req;
    alloc_bid = a_bid;
    rsp_valid = r_v;
    rsp_tag   = r_tag;
    rsp_data  = r_data;
    out_ready = o_rdy;
    fire = a_req && (q.size() < D);
    pop  = o_rdy && (q.size() > 0) && q[0].filled;
    if (r_v) begin
      k = -1;
      foreach (q[i]) if (q[i].tag == r_tag) k = i;
      if (k >= 0 && !q[k].filled) begin
        q[k].filled = 1'b1;
        q[k].data   = r_data;
      end else begin
        m_err = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    if (fire) begin
      q.push_back('{nxt, a_bid, 1'b0, '0});
      nxt++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input bit o_rdy);
    cyc(1'b0, '0, 1'b0, '0, '0, o_rdy);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q.delete();
    nxt   = '0;
    m_err = 1'b0;
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  // Response for a randomly chosen outstanding, unfilled read.
  task automatic pick_unfilled(output bit ok, output logic [TW-1:0] t);
    int idx[$];
    foreach (q[i]) if (!q[i].filled) idx.push_back(i);
    ok = idx.size() > 0;
    t  = '0;
    if (ok) t = q[idx[$urandom_range(idx.size() - 1)]].tag;
  endtask

  task automatic drain();
    bit            ok;
    logic [TW-1:0] t;
    for (int i = 0; i < 4 * D && q.size() > 0; i++) begin
      pick_unfilled(ok, t);
      cyc(1'b0, '0, ok, t, rnd_line(), 1'b1);
    end
    chk("drain_empty", q.size(), 0);
  endtask

  logic [DW-1:0] line;
  bit            ok;
  logic [TW-1:0] t;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    alloc_req = 1'b0;
    alloc_bid = '0;
    rsp_valid = 1'b0;
    rsp_tag   = '0;
    rsp_data  = '0;
    out_ready = 1'b0;
    #1;
    do_reset();

    // in-order
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd1, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      line = DW'(8'hA0 + i);
      cyc(1'b0, '0, 1'b1, TW'(i), line, 1'b1);
    end
    idle(1'b1);

    // reverse order, distinct bids
    for (int i = 0; i < 4; i++) cyc(1'b1, BW'(i + 2), 1'b0, '0, '0, 1'b1);
    for (int i = 3; i >= 0; i--) cyc(1'b0, '0, 1'b1, TW'(4 + i), rnd_line(), 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // reset in the middle of traffic
    cyc(1'b1, 4'd7, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 4'd8, 1'b1, nxt - 1'b1, rnd_line(), 1'b0);
    do_reset();

    // full, then pop with alloc held
    for (int i = 0; i < D; i++) cyc(1'b1, BW'($urandom), 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 4'd3, 1'b1, '0, rnd_line(), 1'b0);
    cyc(1'b1, 4'd3, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 4'd9, 1'b0, '0, '0, 1'b0);

    // random traffic
    for (int i = 0; i < 3 * D * 4; i++) begin
      pick_unfilled(ok, t);
      cyc($urandom_range(1) == 1, BW'($urandom),
          ok && ($urandom_range(2) != 0), t, rnd_line(),
          $urandom_range(3) != 0);
    end
    drain();

    // back-pressure
    cyc(1'b1, 4'd5, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 4'd6, 1'b0, '0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, q[0].tag, rnd_line(), 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) cyc(1'b0, '0, 1'b1, q[1].tag, rnd_line(), 1'b0);
      else        idle(1'b0);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // unexpected responses
    do_reset();
    line = rnd_line();
    cyc(1'b1, 4'd4, 1'b0, '0, '0, 1'b0);
    idle(1'b0);
    cyc(1'b0, '0, 1'b1, 4'd5, rnd_line(), 1'b0);
    cyc(1'b0, '0, 1'b1, 4'd0, line, 1'b0);
    cyc(1'b0, '0, 1'b1, 4'd0, rnd_line(), 1'b0);
    idle(1'b0);
    chk("err_sticky", err_unexp, 1'b1);
    chk("dup_keeps_data", out_data, line);
    idle(1'b1);
    idle(1'b1);
    cyc(1'b1, 4'd2, 1'b1, nxt, rnd_line(), 1'b0);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
